// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function encodings, sequencer state type and default width
package alu_pkg;

  localparam int ALU_OP_WIDTH = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_fun_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/alu_arith_sequencer_if.sv
// rtl/alu_arith_sequencer_if.sv - command and response handshake bundle for the arithmetic sequencer
interface alu_arith_sequencer_if #(
  parameter int OP_WIDTH = alu_pkg::ALU_OP_WIDTH
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [OP_WIDTH-1:0] cmd_a;
  logic [OP_WIDTH-1:0] cmd_b;
  logic [1:0]          cmd_fun;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [OP_WIDTH-1:0] rsp_data;
  logic                rsp_carry;
  logic                rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

endinterface

// File: rtl/alu_arith_sequencer.sv
// rtl/alu_arith_sequencer.sv - one-deep command front-end for the arithmetic unit with status counters
module alu_arith_sequencer
  import alu_pkg::*;
#(
  parameter int OP_WIDTH  = ALU_OP_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  alu_arith_sequencer_if.slave bus,
  output logic [OP_WIDTH-1:0]  arith_a,
  output logic [OP_WIDTH-1:0]  arith_b,
  output logic [1:0]           arith_fun,
  output logic                 arith_en,
  input  logic [OP_WIDTH-1:0]  arith_out,
  input  logic                 arith_carry,
  input  logic                 arith_flag,
  output logic [CNT_WIDTH-1:0] ops_done,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  seq_state_e           r_state;
  seq_state_e           w_next;
  logic [OP_WIDTH-1:0]  r_a;
  logic [OP_WIDTH-1:0]  r_b;
  logic [1:0]           r_fun;
  logic [OP_WIDTH-1:0]  r_rsp_data;
  logic                 r_rsp_carry;
  logic                 r_rsp_err;
  logic [CNT_WIDTH-1:0] r_ops_done;
  logic [CNT_WIDTH-1:0] r_err_count;
  logic                 w_div_zero;

  // Divide-by-zero never reaches the unit; it is answered straight from IDLE.
  assign w_div_zero = (alu_fun_e'(bus.cmd_fun) == ALU_DIV) && (bus.cmd_b == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    arith_en      = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.cmd_ready = RST;
        if (bus.cmd_valid) begin
          w_next = w_div_zero ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        arith_en = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_a         <= '0;
      r_b         <= '0;
      r_fun       <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ops_done  <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_a   <= bus.cmd_a;
            r_b   <= bus.cmd_b;
            r_fun <= bus.cmd_fun;
            if (w_div_zero) begin
              r_rsp_data  <= '1;
              r_rsp_carry <= 1'b0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // The unit's result registered at the end of ISSUE is visible now.
          r_rsp_data  <= arith_out;
          r_rsp_carry <= arith_carry;
          r_rsp_err   <= !arith_flag;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            if (r_ops_done != '1) begin
              r_ops_done <= r_ops_done + CNT_ONE;
            end
            if (r_rsp_err && (r_err_count != '1)) begin
              r_err_count <= r_err_count + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign arith_a       = r_a;
  assign arith_b       = r_b;
  assign arith_fun     = r_fun;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_err   = r_rsp_err;
  assign ops_done      = r_ops_done;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_alu_arith_sequencer.sv
// tb/tb_alu_arith_sequencer.sv - directed and randomized checks of the sequencer against a peer unit model
module tb_alu_arith_sequencer;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [W-1:0]  arith_a;
  logic [W-1:0]  arith_b;
  logic [1:0]    arith_fun;
  logic          arith_en;
  logic [W-1:0]  arith_out;
  logic          arith_carry;
  logic          arith_flag;
  logic [CW-1:0] ops_done;
  logic [CW-1:0] err_count;
  logic          flag_kill = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;
  int exp_err  = 0;

  always #5 CLK = ~CLK;

  alu_arith_sequencer_if #(.OP_WIDTH(W)) bus ();

  alu_arith_sequencer #(.OP_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .arith_a     (arith_a),
    .arith_b     (arith_b),
    .arith_fun   (arith_fun),
    .arith_en    (arith_en),
    .arith_out   (arith_out),
    .arith_carry (arith_carry),
    .arith_flag  (arith_flag),
    .ops_done    (ops_done),
    .err_count   (err_count)
  );

  // {carry, data} is the low 17 bits of the plain arithmetic result.
  function automatic logic [16:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] f);
    logic [31:0] r;
    case (f)
      2'b00:   r = {16'd0, a} + {16'd0, b};
      2'b01:   r = {16'd0, a} - {16'd0, b};
      2'b10:   r = {16'd0, a} * {16'd0, b};
      default: r = (b == 16'd0) ? 32'd0 : {16'd0, a} / {16'd0, b};
    endcase
    return r[16:0];
  endfunction

  // Peer arithmetic unit: result and flag registered one edge after Arith_En.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      arith_out   <= '0;
      arith_carry <= 1'b0;
      arith_flag  <= 1'b0;
    end else begin
      arith_flag <= arith_en && !flag_kill;
      if (arith_en) begin
        {arith_carry, arith_out} <= ref_result(arith_a, arith_b, arith_fun);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f,
                         input logic [15:0] exp_d, input logic exp_c, input logic exp_e,
                         input int hold, input bit keep_valid);
    int  n;
    int  guard;
    int  en_cnt;
    bit  dz;
    dz    = (f == 2'b11) && (b == 16'd0);
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("cmd_ready_before", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_fun   = f;
    tick();
    bus.cmd_valid = 1'b0;
    check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    if (!dz) begin
      check("issue_operands", {arith_a, arith_b}, {a, b});
      check("issue_fun", {30'd0, arith_fun}, {30'd0, f});
    end
    en_cnt = 0;
    n      = 1;
    while (!bus.rsp_valid && n < 10) begin
      if (arith_en) en_cnt++;
      tick();
      n++;
    end
    if (arith_en) en_cnt++;
    check("latency", n, dz ? 32'd1 : 32'd3);
    check("arith_en_cycles", en_cnt, dz ? 32'd0 : 32'd1);
    check("rsp_fields", {14'd0, bus.rsp_data, bus.rsp_carry, bus.rsp_err}, {14'd0, exp_d, exp_c, exp_e});
    if (keep_valid) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = ~a;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_stable", {11'd0, bus.rsp_valid, bus.cmd_ready, arith_en, bus.rsp_data, bus.rsp_carry, bus.rsp_err},
            {11'd0, 1'b1, 1'b0, 1'b0, exp_d, exp_c, exp_e});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_ops = (exp_ops < CNT_MAX) ? exp_ops + 1 : CNT_MAX;
    if (exp_e) exp_err = (exp_err < CNT_MAX) ? exp_err + 1 : CNT_MAX;
    check("ops_done", {28'd0, ops_done}, exp_ops);
    check("err_count", {28'd0, err_count}, exp_err);
    check("after_handshake", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rf;
    logic [16:0] rr;
    bit          kill;
    bit          dz;

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_fun   = '0;
    bus.rsp_ready = 1'b0;
    #12;
    check("reset_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_err, arith_en, bus.rsp_data, arith_fun},
          '0);
    check("reset_regs", {arith_a, arith_b}, '0);
    check("reset_counters", {24'd0, ops_done, err_count}, '0);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    run_cmd(16'hFFFF, 16'h0001, ALU_ADD, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(16'h0005, 16'h0007, ALU_SUB, 16'hFFFE, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(16'h0100, 16'h0100, ALU_MUL, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(16'h0064, 16'h0007, ALU_DIV, 16'h000E, 1'b0, 1'b0, 0, 1'b0);
    run_cmd(16'h1234, 16'h0000, ALU_DIV, 16'hFFFF, 1'b0, 1'b1, 0, 1'b0);
    run_cmd(16'h1000, 16'h0234, ALU_ADD, 16'h1234, 1'b0, 1'b0, 5, 1'b1);
    flag_kill = 1'b1;
    run_cmd(16'h0003, 16'h0004, ALU_MUL, 16'h000C, 1'b0, 1'b1, 0, 1'b0);
    flag_kill = 1'b0;

    for (int k = 0; k < 12; k++) begin
      ra   = 16'($urandom_range(0, 65535));
      rf   = 2'($urandom_range(0, 3));
      rb   = (rf == 2'b11 && $urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
      kill = ($urandom_range(0, 7) == 0);
      dz   = (rf == 2'b11) && (rb == 16'd0);
      rr   = ref_result(ra, rb, rf);
      flag_kill = kill;
      if (dz) run_cmd(ra, rb, rf, 16'hFFFF, 1'b0, 1'b1, $urandom_range(0, 2), 1'b0);
      else    run_cmd(ra, rb, rf, rr[15:0], rr[16], kill, $urandom_range(0, 2), 1'b0);
      flag_kill = 1'b0;
    end
    check("ops_saturated", {28'd0, ops_done}, CNT_MAX);
    run_cmd(16'h0002, 16'h0002, ALU_ADD, 16'h0004, 1'b0, 1'b0, 0, 1'b0);

    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 16'h1111;
    bus.cmd_b     = 16'h2222;
    bus.cmd_fun   = ALU_ADD;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    #2;
    RST = 1'b0;
    #1;
    check("midreset_outputs", {bus.cmd_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_err, arith_en, bus.rsp_data, arith_fun},
          '0);
    check("midreset_regs", {arith_a, arith_b}, '0);
    check("midreset_counters", {24'd0, ops_done, err_count}, '0);
    tick();
    RST     = 1'b1;
    exp_ops = 0;
    exp_err = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_rsp_after_reset", {30'd0, bus.rsp_valid, arith_en}, 32'd0);
    end
    check("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);
    run_cmd(16'h7FFF, 16'h8001, ALU_ADD, 16'h0000, 1'b1, 1'b0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arith_sequencer.md
# alu_arith_sequencer

Command front-end for the 16-bit arithmetic unit. It accepts arithmetic commands over a valid/ready handshake and holds the operands stable. It drives the unit's `Arith_En`/`ALU_FUN`/`A`/`B` for exactly one issue cycle, captures the registered result one cycle later, and returns it over a valid/ready response channel. It also screens divide-by-zero and keeps saturating operation and error counters for status readback.

## Interface
Parameters:
- `OP_WIDTH`, 16: operand/result width; must match the arithmetic unit's `Op_Width`.
- `CNT_WIDTH`, 16: width of the status counters.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_a`  in  OP_WIDTH  operand A.
- `cmd_b`  in  OP_WIDTH  operand B.
- `cmd_fun`  in  2  00 add, 01 sub, 10 mul, 11 div.
- `arith_a`  out  OP_WIDTH  to unit `A`.
- `arith_b`  out  OP_WIDTH  to unit `B`.
- `arith_fun`  out  2  to unit `ALU_FUN`.
- `arith_en`  out  1  to unit `Arith_En`.
- `arith_out`  in  OP_WIDTH  from unit `Arith_Out`.
- `arith_carry`  in  1  from unit `Carry_Out`.
- `arith_flag`  in  1  from unit `Arith_Flag`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  OP_WIDTH  result.
- `rsp_carry`  out  1  carry/borrow/bit OP_WIDTH of the result.
- `rsp_err`  out  1  error: divide-by-zero or missing `arith_flag`.
- `ops_done`  out  CNT_WIDTH  responses delivered; saturating.
- `err_count`  out  CNT_WIDTH  error responses delivered; saturating.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch a, b and fun into holding registers.
  - If fun=11 and b=0: go to RESP with data=all ones, carry=0, err=1.
  - Otherwise go to ISSUE.
- ISSUE:
  - `arith_en`=1 for this single cycle.
  - `arith_a`/`arith_b`/`arith_fun` come from the holding registers and stay stable through WAIT.
  - Always goes to WAIT.
- WAIT:
  - `arith_en`=0.
  - Sample `arith_out`, `arith_carry` and `arith_flag` into the response registers.
  - err = !`arith_flag`.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1.
  - `rsp_data`, `rsp_carry` and `rsp_err` are held stable until `rsp_valid` && `rsp_ready`.
  - On that handshake: return to IDLE, increment `ops_done`, and increment `err_count` if err.
- `cmd_ready`=0 in every state except IDLE. There is one command outstanding at most; there is no queue.
- The counters saturate at all ones and never wrap.
- Reset values:
  - State IDLE.
  - All outputs 0, except `cmd_ready`=1 once out of reset.
  - `arith_*` are 0; holding, response and counter registers are 0.
- A reset asserted in any state returns to IDLE immediately. Any in-flight command is dropped and no response is produced.
- Width rules:
  - Result semantics are the unit's: {carry, data} = the low OP_WIDTH+1 bits of a op b.
  - Sub borrow gives carry=1.
  - Mul bits above OP_WIDTH are lost.

## Timing
- Command accepted at rising edge E0, i.e. `cmd_valid` && `cmd_ready` were high in the cycle before E0.
- Cycle after E0: ISSUE, with `arith_en` high.
- Edge E1: the unit registers its result.
- Cycle after E1: WAIT.
- Edge E2: the response is captured.
- Cycle after E2: `rsp_valid`=1. Latency is E0→`rsp_valid` = 3 edges.
- Divide-by-zero: `rsp_valid` is high in the cycle after E0 (1 edge), and `arith_en` is never asserted.
- Best-case throughput is one command per 4 cycles. `cmd_ready` re-asserts in the cycle after the response handshake edge.
- `rsp_valid` must not drop, and `rsp_data` must not change, while `rsp_ready`=0.

## Structure
- Shared package `alu_pkg`:
  - ALU_FUN encodings ADD/SUB/MUL/DIV (00/01/10/11).
  - FSM state type.
  - Default OP_WIDTH.
  - The arithmetic unit must also use these encodings.
- No sub-module.
- The FSM, holding/response registers and counters fit in one module.
- The arithmetic unit is a peer, instantiated alongside this block at the top level and not inside it.

## Test plan
- Add 0xFFFF+0x0001, with `rsp_ready`=1 → `rsp_valid` 3 edges after accept, data 0x0000, carry 1, err 0, `ops_done`=1.
- Sub 0x0005−0x0007 → data 0xFFFE, carry 1. Mul 0x0100×0x0100 → data 0x0000, carry 1. Div 0x0064/0x0007 → data 0x000E, carry 0.
- Div 0x1234/0x0000 → `rsp_valid` 1 edge after accept, data 0xFFFF, err 1, `arith_en` never high, `err_count`=1.
- Hold `rsp_ready`=0 for 5 cycles after `rsp_valid`, with `cmd_valid` held high → response stable, `cmd_ready`=0 throughout. Release → next command is accepted the cycle after the handshake.
- Force `arith_flag`=0 during WAIT → `rsp_err`=1 and `err_count` increments.
- Assert RST during WAIT → all outputs 0 immediately, no response after release, `cmd_ready`=1. A preloaded counter at 0xFFFF stays 0xFFFF after a further response.
